// File: rtl/datapath_bus_arbiter_pkg.sv
// rtl/datapath_bus_arbiter_pkg.sv - shared constants for the operand-bus arbiter
package datapath_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic SEL_REQ0 = 1'b0;
    localparam logic SEL_REQ1 = 1'b1;

    localparam int MAX_HOLD_DEF = 8;
    localparam int HOLD_W_DEF   = 4;

endpackage

// File: rtl/datapath_bus_arbiter_tenure_counter.sv
// rtl/datapath_bus_arbiter_tenure_counter.sv - saturating tenure counter with terminal count
module tenure_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 7
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LP_LIMIT = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LP_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/datapath_bus_arbiter.sv
// rtl/datapath_bus_arbiter.sv - round-robin two-requester arbiter with bounded tenure
module datapath_bus_arbiter
    import datapath_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = HOLD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_sel,
    output logic              o_bus_busy,
    output logic [HOLD_W-1:0] o_hold_cnt
);

    state_t r_state;
    state_t w_next_state;
    logic   r_gnt0, r_gnt1, r_sel, r_bus_busy, r_last_owner;
    logic   w_gnt0_nxt, w_gnt1_nxt, w_sel_nxt, w_busy_nxt, w_last_nxt;
    logic   w_tc, w_cnt_clear, w_cnt_en;

    // Counter restarts on reset, any ownership change and while idle; otherwise it counts the stay.
    assign w_cnt_clear = i_reset || (w_next_state != r_state) || (w_next_state == ST_IDLE);
    assign w_cnt_en    = !w_cnt_clear;

    tenure_counter #(
        .W     (HOLD_W),
        .LIMIT (MAX_HOLD - 1)
    ) u_tenure (
        .i_clk   (i_clk),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_cnt   (o_hold_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_sel        <= SEL_REQ0;
            r_bus_busy   <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_gnt0       <= w_gnt0_nxt;
            r_gnt1       <= w_gnt1_nxt;
            r_sel        <= w_sel_nxt;
            r_bus_busy   <= w_busy_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req0 && i_req1) begin
                    w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (i_req0) begin
                    w_next_state = ST_OWN0;
                end else if (i_req1) begin
                    w_next_state = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!i_req0) begin
                    w_next_state = i_req1 ? ST_OWN1 : ST_IDLE;
                end else if (i_req1 && w_tc) begin
                    w_next_state = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!i_req1) begin
                    w_next_state = i_req0 ? ST_OWN0 : ST_IDLE;
                end else if (i_req0 && w_tc) begin
                    w_next_state = ST_OWN0;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // sel and last_owner only move when a grant is issued, so they hold through IDLE.
    always_comb begin
        w_gnt0_nxt = (w_next_state == ST_OWN0);
        w_gnt1_nxt = (w_next_state == ST_OWN1);
        w_busy_nxt = (w_next_state != ST_IDLE);
        w_sel_nxt  = r_sel;
        w_last_nxt = r_last_owner;
        if (w_next_state == ST_OWN0) begin
            w_sel_nxt  = SEL_REQ0;
            w_last_nxt = 1'b0;
        end else if (w_next_state == ST_OWN1) begin
            w_sel_nxt  = SEL_REQ1;
            w_last_nxt = 1'b1;
        end
    end

    assign o_gnt0     = r_gnt0;
    assign o_gnt1     = r_gnt1;
    assign o_sel      = r_sel;
    assign o_bus_busy = r_bus_busy;

endmodule

// File: tb/tb_datapath_bus_arbiter.sv
// tb/tb_datapath_bus_arbiter.sv - directed self-checking bench for datapath_bus_arbiter
module tb_datapath_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic       gnt0, gnt1, sel, bus_busy;
    logic [3:0] hold_cnt;
    logic       gnt0_m1, gnt1_m1, sel_m1, bus_busy_m1;
    logic [0:0] hold_cnt_m1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datapath_bus_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req0     (req0),
        .i_req1     (req1),
        .o_gnt0     (gnt0),
        .o_gnt1     (gnt1),
        .o_sel      (sel),
        .o_bus_busy (bus_busy),
        .o_hold_cnt (hold_cnt)
    );

    datapath_bus_arbiter #(.MAX_HOLD(1), .HOLD_W(1)) u_dut_m1 (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_req0     (req0),
        .i_req1     (req1),
        .o_gnt0     (gnt0_m1),
        .o_gnt1     (gnt1_m1),
        .o_sel      (sel_m1),
        .o_bus_busy (bus_busy_m1),
        .o_hold_cnt (hold_cnt_m1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Packed as {gnt0, gnt1, sel, bus_busy, hold_cnt[3:0]}
    task automatic expect_out(input string tag, input logic g0, input logic g1,
                              input logic s, input logic b, input int h);
        logic [7:0] exp_v;
        logic [3:0] h4;
        h4    = h[3:0];
        exp_v = {g0, g1, s, b, h4};
        check_eq(tag, {24'd0, gnt0, gnt1, sel, bus_busy, hold_cnt}, {24'd0, exp_v});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int owner;
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("reset_%0d", i), 0, 0, 0, 0, 0);
        end

        // Continuous contention: MAX_HOLD=8 alternates in blocks of 8, MAX_HOLD=1 every cycle.
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            owner = (k / 8) % 2;
            expect_out($sformatf("contend_%0d", k), owner == 0, owner == 1, owner[0], 1, k % 8);
            owner = k % 2;
            check_eq($sformatf("contend_m1_%0d", k),
                     {27'd0, gnt0_m1, gnt1_m1, sel_m1, bus_busy_m1, hold_cnt_m1},
                     {27'd0, owner == 0, owner == 1, owner[0], 1'b1, 1'b0});
        end

        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b0;
        step();
        reset = 1'b0;
        step();
        expect_out("own0_start", 1, 0, 0, 1, 0);
        req1 = 1'b1;
        step();
        expect_out("own0_h1", 1, 0, 0, 1, 1);
        step();
        expect_out("own0_h2", 1, 0, 0, 1, 2);
        req0 = 1'b0;
        step();
        expect_out("release_handoff", 0, 1, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out($sformatf("own1_sat_%0d", i), 0, 1, 1, 1, (i + 1 > 7) ? 7 : i + 1);
        end
        req1 = 1'b0;
        step();
        expect_out("idle_sel_hold", 0, 0, 1, 0, 0);

        req0 = 1'b1;
        step();
        expect_out("pulse_grant", 1, 0, 0, 1, 0);
        req0 = 1'b0;
        step();
        expect_out("pulse_release", 0, 0, 0, 0, 0);

        req0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out($sformatf("own0_alone_%0d", i), 1, 0, 0, 1, (i > 7) ? 7 : i);
        end
        req1 = 1'b1;
        step();
        expect_out("late_preempt", 0, 1, 1, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_out($sformatf("own1_contend_%0d", i), 0, 1, 1, 1, i);
        end
        reset = 1'b1;
        step();
        expect_out("reset_mid_tenure", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        expect_out("post_reset_tie", 1, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
